// File: rtl/seq_abs_diff_alu.sv
// rtl/seq_abs_diff_alu.sv - digit-serial ADD/SUB/|A-B| engine with borrow/carry flags and done pulse
// One operation in flight; the accumulator fills from the top as digits are summed LSB first.
module seq_abs_diff_alu #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             rdy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             neg
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("seq_abs_diff_alu: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_NEG, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_c;
  logic             r_sub;
  logic             r_abs;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT:0]         w_sum;
  logic [WIDTH+DIGIT-1:0] w_cat;
  logic [WIDTH-1:0]       w_acc_next;
  logic [WIDTH-1:0]       w_acc_neg;
  logic                   w_c;

  assign w_sum      = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};
  assign w_c        = w_sum[DIGIT];
  assign w_cat      = {w_sum[DIGIT-1:0], r_acc};
  assign w_acc_next = w_cat[WIDTH+DIGIT-1:DIGIT];
  assign w_acc_neg  = ~r_acc + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_c     <= 1'b0;
      r_sub   <= 1'b0;
      r_abs   <= 1'b0;
      r_cnt   <= '0;
      rdy     <= 1'b1;
      done    <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      neg     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1, so B is inverted and carry-in preset.
            r_a     <= A;
            r_b     <= (mode != 2'b00) ? ~B : B;
            r_sub   <= (mode != 2'b00);
            r_abs   <= (mode == 2'b10);
            r_c     <= (mode != 2'b00);
            r_cnt   <= '0;
            r_state <= S_CALC;
            rdy     <= 1'b0;
          end
        end
        S_CALC: begin
          r_acc <= w_acc_next;
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_c   <= w_c;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            if (r_abs && !w_c) begin
              r_state <= S_NEG;
            end else begin
              result  <= w_acc_next;
              carry   <= r_sub ? ~w_c : w_c;
              neg     <= r_sub & ~w_c;
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_NEG: begin
          // r_c still holds the final carry-out, which was 0 to get here.
          r_acc   <= w_acc_neg;
          result  <= w_acc_neg;
          carry   <= ~r_c;
          neg     <= ~r_c;
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          rdy     <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          rdy     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_abs_diff_alu.sv
// tb/tb_seq_abs_diff_alu.sv - directed and golden-model checks across four parameter sets
module tb_seq_abs_diff_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  st = 4'b0000;
  logic [1:0]  mode = 2'b00;
  logic [15:0] a_in = 16'h0000;
  logic [15:0] b_in = 16'h0000;

  logic [3:0]  rdy_v, done_v, carry_v, neg_v;
  logic [15:0] res_v [4];
  logic [7:0]  res3;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] bb_a [3] = '{16'h0100, 16'h0001, 16'h0010};
  logic [15:0] bb_b [3] = '{16'h0023, 16'h0010, 16'h0001};
  logic [1:0]  bb_m [3] = '{2'b00, 2'b10, 2'b01};
  logic [15:0] bb_r [3] = '{16'h0123, 16'h000F, 16'h000F};
  int          bb_l [3] = '{5, 6, 5};

  always #5 clk = ~clk;

  seq_abs_diff_alu #(.WIDTH(16), .DIGIT(4)) u_w16_d4 (
    .clk(clk), .rst(rst), .start(st[0]), .mode(mode), .A(a_in), .B(b_in),
    .rdy(rdy_v[0]), .done(done_v[0]), .result(res_v[0]), .carry(carry_v[0]), .neg(neg_v[0]));
  seq_abs_diff_alu #(.WIDTH(16), .DIGIT(1)) u_w16_d1 (
    .clk(clk), .rst(rst), .start(st[1]), .mode(mode), .A(a_in), .B(b_in),
    .rdy(rdy_v[1]), .done(done_v[1]), .result(res_v[1]), .carry(carry_v[1]), .neg(neg_v[1]));
  seq_abs_diff_alu #(.WIDTH(16), .DIGIT(16)) u_w16_d16 (
    .clk(clk), .rst(rst), .start(st[2]), .mode(mode), .A(a_in), .B(b_in),
    .rdy(rdy_v[2]), .done(done_v[2]), .result(res_v[2]), .carry(carry_v[2]), .neg(neg_v[2]));
  seq_abs_diff_alu #(.WIDTH(8), .DIGIT(2)) u_w8_d2 (
    .clk(clk), .rst(rst), .start(st[3]), .mode(mode), .A(a_in[7:0]), .B(b_in[7:0]),
    .rdy(rdy_v[3]), .done(done_v[3]), .result(res3), .carry(carry_v[3]), .neg(neg_v[3]));

  assign res_v[3] = {8'h00, res3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Golden model: plain wide arithmetic, latency counted in cycles from accept to done inclusive.
  task automatic op(input int k, input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
    int          w, n, lat, elat;
    logic [16:0] mask, s;
    logic [15:0] aa, bb, er;
    logic        ec, en;
    w    = (k == 3) ? 8 : 16;
    n    = (k == 1) ? 16 : (k == 2) ? 1 : 4;
    mask = (17'd1 << w) - 17'd1;
    aa   = a & mask[15:0];
    bb   = b & mask[15:0];
    if (m == 2'b00) begin
      s  = {1'b0, aa} + {1'b0, bb};
      er = s[15:0] & mask[15:0];
      ec = s[w];
      en = 1'b0;
    end else begin
      ec = (aa < bb);
      en = ec;
      er = (m == 2'b10 && ec) ? (bb - aa) : ((aa - bb) & mask[15:0]);
    end
    elat = n + 1 + ((m == 2'b10 && ec) ? 1 : 0);
    @(negedge clk);
    chk("rdy_idle", {31'd0, rdy_v[k]}, 32'd1);
    a_in = a; b_in = b; mode = m; st[k] = 1'b1;
    @(negedge clk);
    st[k] = 1'b0; a_in = ~a; b_in = 16'h5A5A; mode = ~m;
    lat = 1;
    while (!done_v[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, elat);
    chk("result", {16'd0, res_v[k]}, {16'd0, er});
    chk("carry", {31'd0, carry_v[k]}, {31'd0, ec});
    chk("neg", {31'd0, neg_v[k]}, {31'd0, en});
    @(negedge clk);
    chk("rdy_after", {31'd0, rdy_v[k]}, 32'd1);
    chk("result_held", {16'd0, res_v[k]}, {16'd0, er});
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", {31'd0, rdy_v[0]}, 32'd1);
    chk("rst_done", {31'd0, done_v[0]}, 32'd0);
    chk("rst_result", {16'd0, res_v[0]}, 32'd0);
    chk("rst_carry", {31'd0, carry_v[0]}, 32'd0);
    chk("rst_neg", {31'd0, neg_v[0]}, 32'd0);

    op(0, 2'b00, 16'hFFFF, 16'h0001);
    op(0, 2'b01, 16'h0003, 16'h0005);
    op(0, 2'b10, 16'h0003, 16'h0005);
    op(0, 2'b10, 16'h1234, 16'h1234);
    op(0, 2'b10, 16'h8000, 16'h0001);
    op(0, 2'b11, 16'h0010, 16'h0001);
    op(0, 2'b00, 16'h1234, 16'h4321);

    // start pulsed mid-operation must be ignored
    @(negedge clk);
    a_in = 16'h1000; b_in = 16'h0234; mode = 2'b00; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    a_in = 16'hFFFF; b_in = 16'hFFFF; mode = 2'b01; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    lat = 3;
    while (!done_v[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("ign_latency", lat, 5);
    chk("ign_result", {16'd0, res_v[0]}, 32'h1234);
    chk("ign_carry", {31'd0, carry_v[0]}, 32'd0);
    @(negedge clk);
    chk("ign_rdy1", {31'd0, rdy_v[0]}, 32'd1);
    @(negedge clk);
    chk("ign_rdy2", {31'd0, rdy_v[0]}, 32'd1);

    // reset during CALC aborts without done
    a_in = 16'h0003; b_in = 16'h0005; mode = 2'b10; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    chk("abort_c1_done", {31'd0, done_v[0]}, 32'd0);
    @(negedge clk);
    chk("abort_c2_done", {31'd0, done_v[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_done", {31'd0, done_v[0]}, 32'd0);
    chk("abort_result", {16'd0, res_v[0]}, 32'd0);
    chk("abort_rdy", {31'd0, rdy_v[0]}, 32'd1);
    chk("abort_neg", {31'd0, neg_v[0]}, 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done_v[0]}, 32'd0);
    end

    // parameter sweep
    op(1, 2'b10, 16'h0003, 16'h0005);
    op(1, 2'b00, 16'hFFFF, 16'h0001);
    op(2, 2'b00, 16'hFFFF, 16'h0001);
    op(2, 2'b10, 16'h0001, 16'h8000);
    op(3, 2'b01, 16'h0003, 16'h0005);
    op(3, 2'b10, 16'h0003, 16'h0005);
    op(3, 2'b00, 16'h00FF, 16'h0001);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 6; i++) begin
        op(k, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
      end
    end

    // start held high: back-to-back operations
    @(negedge clk);
    a_in = bb_a[0]; b_in = bb_b[0]; mode = bb_m[0]; st[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_busy", {31'd0, rdy_v[0]}, 32'd0);
      lat = 1;
      while (!done_v[0] && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      chk("b2b_latency", lat, bb_l[i]);
      chk("b2b_result", {16'd0, res_v[0]}, {16'd0, bb_r[i]});
      @(negedge clk);
      chk("b2b_rdy", {31'd0, rdy_v[0]}, 32'd1);
      if (i < 2) begin
        a_in = bb_a[i+1]; b_in = bb_b[i+1]; mode = bb_m[i+1];
      end else begin
        st[0] = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_idle", {31'd0, rdy_v[0]}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
